// File: rtl/r22sdf_frame_ctrl.sv
// Frame sequencer for the 256-point R2^2 SDF FFT: sole driver of the core enable,
// inserts drain cycles after the last frame and tags core outputs with frame markers.
module r22sdf_frame_ctrl #(
   parameter int data_resolution = 16,
   parameter int fft_length      = 256,
   parameter int cnt_w           = 8,
   parameter int pipe_lat        = 255
) (
   input  logic                       sys_clk,
   input  logic                       sys_rst,
   input  logic                       cfg_start,
   input  logic [15:0]                cfg_frames,
   input  logic                       cfg_stop,
   input  logic                       s_valid,
   output logic                       s_ready,
   input  logic [data_resolution-1:0] s_din_r,
   input  logic [data_resolution-1:0] s_din_i,
   output logic                       fft_en,
   input  logic                       fft_rdy,
   output logic [data_resolution-1:0] fft_din_r,
   output logic [data_resolution-1:0] fft_din_i,
   input  logic [data_resolution-1:0] fft_dout_r,
   input  logic [data_resolution-1:0] fft_dout_i,
   output logic                       m_valid,
   output logic                       m_sop,
   output logic                       m_eop,
   output logic [cnt_w-1:0]           m_bin,
   output logic [data_resolution-1:0] m_dout_r,
   output logic [data_resolution-1:0] m_dout_i,
   output logic                       busy,
   output logic                       done
);
   localparam int lat_w = $clog2(pipe_lat + 1);
   localparam logic [lat_w-1:0] lat_max  = lat_w'(pipe_lat);
   localparam logic [cnt_w-1:0] cnt_last = cnt_w'(fft_length - 1);

   typedef enum logic [2:0] {IDLE, WAIT_RDY, RUN, FLUSH, DONE} state_t;

   state_t                     state_q, state_d;
   logic [15:0]                tgt_q, tgt_d;
   logic                       cont_q, cont_d;
   logic                       stop_pend_q, stop_pend_d;
   logic [cnt_w-1:0]           in_cnt_q, in_cnt_d;
   logic [cnt_w-1:0]           out_cnt_q, out_cnt_d;
   logic [lat_w-1:0]           lat_cnt_q, lat_cnt_d;
   logic [15:0]                frames_in_q, frames_in_d;
   logic [15:0]                frames_out_q, frames_out_d;
   logic                       m_valid_q, m_valid_d;
   logic                       m_sop_q, m_sop_d;
   logic                       m_eop_q, m_eop_d;
   logic [cnt_w-1:0]           m_bin_q, m_bin_d;
   logic [data_resolution-1:0] m_dout_r_q, m_dout_r_d;
   logic [data_resolution-1:0] m_dout_i_q, m_dout_i_d;

   logic stop_now, hold_input, accept, capture, out_ok;
   logic [cnt_w-1:0] bin_rev;

   // Handshake and core enable; fft_din is left combinational because the core registers it.
   always_comb begin
      // NOTE: every comb output gets a default first, so no branch can leave one unassigned (latch).
      s_ready   = 1'b0;
      fft_en    = 1'b0;
      fft_din_r = '0;
      fft_din_i = '0;
      stop_now   = cont_q & (stop_pend_q | cfg_stop);
      hold_input = stop_now & (in_cnt_q == '0) & (frames_in_q != '0);
      out_ok     = ((state_q == RUN) & cont_q) | (frames_out_q != tgt_q);
      if (state_q == RUN) begin
         s_ready   = fft_rdy & ~hold_input;
         fft_en    = s_valid & s_ready;
         fft_din_r = s_din_r;
         fft_din_i = s_din_i;
      end else if (state_q == FLUSH) begin
         fft_en = fft_rdy & (frames_out_q != tgt_q);
      end
      accept  = s_valid & s_ready;
      capture = fft_en & (lat_cnt_q == lat_max) & out_ok;
      for (int b = 0; b < cnt_w; b++) bin_rev[b] = out_cnt_q[cnt_w-1-b];
   end

   always_comb begin
      state_d      = state_q;
      tgt_d        = tgt_q;
      cont_d       = cont_q;
      stop_pend_d  = stop_pend_q;
      in_cnt_d     = in_cnt_q;
      out_cnt_d    = out_cnt_q;
      lat_cnt_d    = lat_cnt_q;
      frames_in_d  = frames_in_q;
      frames_out_d = frames_out_q;
      m_valid_d    = 1'b0;
      m_sop_d      = 1'b0;
      m_eop_d      = 1'b0;
      m_bin_d      = m_bin_q;
      m_dout_r_d   = m_dout_r_q;
      m_dout_i_d   = m_dout_i_q;

      if (state_q == IDLE) begin
         in_cnt_d     = '0;
         out_cnt_d    = '0;
         lat_cnt_d    = '0;
         frames_in_d  = '0;
         frames_out_d = '0;
         stop_pend_d  = 1'b0;
      end
      if (accept) begin
         in_cnt_d = in_cnt_q + 1'b1;
         if (in_cnt_q == cnt_last) frames_in_d = frames_in_q + 16'd1;
      end
      if (fft_en && lat_cnt_q != lat_max) lat_cnt_d = lat_cnt_q + 1'b1;
      if (capture) begin
         out_cnt_d  = out_cnt_q + 1'b1;
         if (out_cnt_q == cnt_last) frames_out_d = frames_out_q + 16'd1;
         m_valid_d  = 1'b1;
         m_sop_d    = (out_cnt_q == '0);
         m_eop_d    = (out_cnt_q == cnt_last);
         m_bin_d    = bin_rev;
         m_dout_r_d = fft_dout_r;
         m_dout_i_d = fft_dout_i;
      end

      unique case (state_q)
         IDLE: if (cfg_start) begin
            state_d = WAIT_RDY;
            tgt_d   = cfg_frames;
            cont_d  = (cfg_frames == '0);
         end
         WAIT_RDY: if (fft_rdy) state_d = RUN;
         RUN: begin
            if (cfg_stop && cont_q) stop_pend_d = 1'b1;
            // Continuous mode fixes the output target at the moment input ends.
            if (hold_input) begin
               state_d = FLUSH;
               tgt_d   = frames_in_q;
            end else if (accept && in_cnt_q == cnt_last &&
                         (cont_q ? stop_now : (frames_in_d == tgt_q))) begin
               state_d = FLUSH;
               if (cont_q) tgt_d = frames_in_d;
            end
         end
         FLUSH: if (frames_out_q == tgt_q) state_d = DONE;
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses <= so every flop samples the same pre-edge values.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q      <= IDLE;
         tgt_q        <= '0;
         cont_q       <= 1'b0;
         stop_pend_q  <= 1'b0;
         in_cnt_q     <= '0;
         out_cnt_q    <= '0;
         lat_cnt_q    <= '0;
         frames_in_q  <= '0;
         frames_out_q <= '0;
         m_valid_q    <= 1'b0;
         m_sop_q      <= 1'b0;
         m_eop_q      <= 1'b0;
         m_bin_q      <= '0;
         m_dout_r_q   <= '0;
         m_dout_i_q   <= '0;
      end else begin
         state_q      <= state_d;
         tgt_q        <= tgt_d;
         cont_q       <= cont_d;
         stop_pend_q  <= stop_pend_d;
         in_cnt_q     <= in_cnt_d;
         out_cnt_q    <= out_cnt_d;
         lat_cnt_q    <= lat_cnt_d;
         frames_in_q  <= frames_in_d;
         frames_out_q <= frames_out_d;
         m_valid_q    <= m_valid_d;
         m_sop_q      <= m_sop_d;
         m_eop_q      <= m_eop_d;
         m_bin_q      <= m_bin_d;
         m_dout_r_q   <= m_dout_r_d;
         m_dout_i_q   <= m_dout_i_d;
      end
   end

   assign m_valid  = m_valid_q;
   assign m_sop    = m_sop_q;
   assign m_eop    = m_eop_q;
   assign m_bin    = m_bin_q;
   assign m_dout_r = m_dout_r_q;
   assign m_dout_i = m_dout_i_q;
   assign busy     = (state_q != IDLE);
   assign done     = (state_q == DONE);
endmodule

// File: tb/tb_r22sdf_frame_ctrl.sv
// Randomized scoreboard bench for r22sdf_frame_ctrl: a delay-line core model feeds the
// DUT; accepted samples predict the tagged output stream, which a monitor compares.
module tb_r22sdf_frame_ctrl;
   localparam int DW  = 16;
   localparam int N   = 256;
   localparam int CW  = 8;
   localparam int LAT = 255;

   logic          sys_clk = 1'b0;
   logic          sys_rst = 1'b1;
   logic          cfg_start = 1'b0, cfg_stop = 1'b0, s_valid = 1'b0, fft_rdy = 1'b0;
   logic [15:0]   cfg_frames = '0;
   logic [DW-1:0] s_din_r = '0, s_din_i = '0;
   logic          s_ready, fft_en, m_valid, m_sop, m_eop, busy, done;
   logic [DW-1:0] fft_din_r, fft_din_i, fft_dout_r, fft_dout_i, m_dout_r, m_dout_i;
   logic [CW-1:0] m_bin;

   r22sdf_frame_ctrl #(.data_resolution(DW), .fft_length(N), .cnt_w(CW), .pipe_lat(LAT)) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .cfg_start(cfg_start), .cfg_frames(cfg_frames),
      .cfg_stop(cfg_stop), .s_valid(s_valid), .s_ready(s_ready), .s_din_r(s_din_r),
      .s_din_i(s_din_i), .fft_en(fft_en), .fft_rdy(fft_rdy), .fft_din_r(fft_din_r),
      .fft_din_i(fft_din_i), .fft_dout_r(fft_dout_r), .fft_dout_i(fft_dout_i),
      .m_valid(m_valid), .m_sop(m_sop), .m_eop(m_eop), .m_bin(m_bin),
      .m_dout_r(m_dout_r), .m_dout_i(m_dout_i), .busy(busy), .done(done));

   always #5 sys_clk = ~sys_clk;

   // Core stand-in: a pure delay of LAT enabled cycles, so outputs replay inputs in order.
   logic [2*DW-1:0] core_pipe [LAT];
   always @(posedge sys_clk) begin
      if (sys_rst) begin
         for (int i = 0; i < LAT; i++) core_pipe[i] <= '0;
      end else if (fft_en) begin
         core_pipe[0] <= {fft_din_r, fft_din_i};
         for (int i = 1; i < LAT; i++) core_pipe[i] <= core_pipe[i-1];
      end
   end
   assign {fft_dout_r, fft_dout_i} = core_pipe[LAT-1];

   typedef struct packed {
      logic [2*DW-1:0] data;
      logic            sop;
      logic            eop;
      logic [CW-1:0]   bin;
   } exp_t;
   exp_t sb[$];

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [CW-1:0] bitrev(input int idx);
      int r = 0;
      int v = idx;
      for (int i = 0; i < CW; i++) begin
         r = r * 2 + (v % 2);
         v = v / 2;
      end
      return CW'(r);
   endfunction

   // Monitor: owns output counters; compares every m_valid word against the scoreboard.
   logic en_prev = 1'b0;
   int   mon_cyc = 0, n_out = 0, n_done = 0, last_eop_cyc = -100;
   always @(negedge sys_clk) begin
      #1;
      en_prev = fft_en;
   end
   always @(posedge sys_clk) begin
      exp_t e;
      #1;
      mon_cyc++;
      if (!sys_rst) begin
         if (m_valid) begin
            n_out++;
            check("valid_after_en", en_prev, 1);
            check("out_expected", sb.size() != 0, 1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               check("out_word", {m_dout_r, m_dout_i, m_sop, m_eop, m_bin}, e);
            end
            if (m_eop) last_eop_cyc = mon_cyc;
         end
         if (done) begin
            n_done++;
            check("done_lag", mon_cyc - last_eop_cyc, 1);
         end
      end
   end

   int n_acc, n_ready, n_flush, n_flush_nz, n_en, n_rdy_viol, n_after_stop;
   int first_acc, rise, out_base, done_base, job_out, job_done;
   logic finished, aborted;

   task automatic run_job(input int nframes, input int gap_mode, input int rdy_hold,
                          input bit rdy_drop, input int stop_at, input int abort_at);
      exp_t item;
      int   idx, tail;
      bit   stop_sent;
      n_acc = 0; n_ready = 0; n_flush = 0; n_flush_nz = 0; n_en = 0; n_rdy_viol = 0;
      n_after_stop = 0; first_acc = -1; rise = -1; tail = 0; stop_sent = 0;
      finished = 0; aborted = 0;
      out_base = n_out; done_base = n_done;
      for (int c = 0; c < 6000 && !finished; c++) begin
         @(negedge sys_clk);
         cfg_start  = (c == 0);
         cfg_frames = 16'(nframes);
         fft_rdy    = (c > rdy_hold) && !(rdy_drop && $urandom_range(0, 7) == 0);
         if (fft_rdy && rise < 0) rise = c;
         case (gap_mode)
            0:       s_valid = 1'b1;
            1:       s_valid = c[0];
            default: s_valid = ($urandom_range(0, 3) != 0);
         endcase
         s_din_r  = DW'($urandom);
         s_din_i  = DW'($urandom);
         cfg_stop = (stop_at >= 0) && !stop_sent && (n_acc == stop_at);
         if (cfg_stop) stop_sent = 1;
         if (abort_at >= 0 && c > 0 && n_acc == abort_at) begin
            sys_rst  = 1'b1;
            aborted  = 1;
            finished = 1;
            continue;
         end
         #1;
         if (!fft_rdy && (fft_en || s_ready)) n_rdy_viol++;
         if (s_ready) n_ready++;
         if (fft_en) n_en++;
         if (s_valid && s_ready) begin
            if (first_acc < 0) first_acc = c;
            if (stop_sent) n_after_stop++;
            idx       = n_acc % N;
            item.data = {s_din_r, s_din_i};
            item.sop  = (idx == 0);
            item.eop  = (idx == N - 1);
            item.bin  = bitrev(idx);
            sb.push_back(item);
            n_acc++;
         end else if (fft_en) begin
            n_flush++;
            if (fft_din_r != '0 || fft_din_i != '0) n_flush_nz++;
         end
         if (n_done != done_base) tail++;
         if (tail >= 4) finished = 1;
      end
      cfg_start = 1'b0;
      cfg_stop  = 1'b0;
      s_valid   = 1'b0;
      check("job_finished", finished, 1);
      job_out  = n_out - out_base;
      job_done = n_done - done_base;
   endtask

   task automatic check_quiet(input string name);
      check({name, "_ctl"}, {s_ready, fft_en, m_valid, m_sop, m_eop, busy, done, m_bin}, 0);
      check({name, "_dat"}, {fft_din_r, fft_din_i, m_dout_r, m_dout_i}, 0);
   endtask

   initial begin
      int nf;
      // Reset with random inputs, including start requests that must be ignored.
      sys_rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge sys_clk);
         cfg_start = 1'b1; cfg_frames = 16'($urandom); cfg_stop = 1'($urandom);
         s_valid = 1'($urandom); fft_rdy = 1'($urandom);
         s_din_r = DW'($urandom); s_din_i = DW'($urandom);
         #1;
         check_quiet("reset");
      end
      @(negedge sys_clk);
      sys_rst = 1'b0; cfg_start = 1'b0; cfg_stop = 1'b0; s_valid = 1'b0; fft_rdy = 1'b1;
      repeat (2) @(negedge sys_clk);
      #1;
      check("idle_after_rst", busy, 0);

      // Single frame, back-to-back samples.
      run_job(1, 0, 0, 0, -1, -1);
      check("t2_ready_cycles", n_ready, N);
      check("t2_flush_cycles", n_flush, LAT);
      check("t2_flush_zero", n_flush_nz, 0);
      check("t2_outputs", job_out, N);
      check("t2_done", job_done, 1);
      check("t2_sb_drained", sb.size(), 0);

      // Core not ready for 20 cycles after start.
      run_job(1, 0, 20, 0, -1, -1);
      check("t3_rdy_gating", n_rdy_viol, 0);
      check("t3_first_acc", (first_acc == rise) || (first_acc == rise + 1), 1);
      check("t3_outputs", job_out, N);
      check("t3_done", job_done, 1);

      // Two frames with alternating valid.
      run_job(2, 1, 0, 0, -1, -1);
      check("t4_outputs", job_out, 2 * N);
      check("t4_en_cycles", n_en, 2 * N + LAT);
      check("t4_done", job_done, 1);
      check("t4_sb_drained", sb.size(), 0);

      // Continuous mode, stop requested at sample 100 of the third frame.
      run_job(0, 2, 0, 0, 2 * N + 100, -1);
      check("t5_after_stop", n_after_stop, N - 100);
      check("t5_accepted", n_acc, 3 * N);
      check("t5_outputs", job_out, 3 * N);
      check("t5_done", job_done, 1);
      check("t5_sb_drained", sb.size(), 0);

      // Reset mid-run at sample 50, then a clean restart.
      run_job(1, 0, 0, 0, -1, 50);
      check("t6_aborted", aborted, 1);
      check("t6_no_out", job_out, 0);
      @(negedge sys_clk);
      #1;
      check_quiet("t6_reset");
      sb.delete();
      @(negedge sys_clk);
      sys_rst = 1'b0;
      run_job(1, 2, 0, 1, -1, -1);
      check("t6_outputs", job_out, N);
      check("t6_done", job_done, 1);

      // Random frame count with random valid gaps and core-ready drops.
      for (int k = 0; k < 2; k++) begin
         nf = $urandom_range(1, 2);
         run_job(nf, 2, $urandom_range(0, 5), 1, -1, -1);
         check("t7_rdy_gating", n_rdy_viol, 0);
         check("t7_outputs", job_out, nf * N);
         check("t7_en_cycles", n_en, nf * N + LAT);
         check("t7_done", job_done, 1);
         check("t7_sb_drained", sb.size(), 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/r22sdf_frame_ctrl.md
Name: r22sdf_frame_ctrl

Overview:
Frame sequencer for the 256-point R2^2 SDF FFT pipeline. It accepts a valid/ready sample stream, drives the pipeline's global enable and data inputs, and waits for twiddle/CORDIC readiness. After the last frame it inserts zero-flush cycles to drain the pipeline. It also tags pipeline outputs with valid, start/end-of-frame and bit-reversed bin index. It sits between the sample source and the four-stage FFT core, and is the only driver of the core's enable.

Parameters:
data_resolution, 16, sample width per real/imag component
fft_length, 256, points per frame (power of 4)
cnt_w, 8, log2(fft_length)
pipe_lat, 255, enabled cycles from a frame's first input to its first output; must be >= 1

Ports:
sys_clk  in  1  clock
sys_rst  in  1  synchronous active-high reset
cfg_start  in  1  one-cycle start pulse; ignored unless IDLE
cfg_frames  in  16  frames to process, latched at start; 0 = continuous
cfg_stop  in  1  continuous mode only: finish the current input frame, then flush
s_valid  in  1  input sample valid
s_ready  out  1  input sample accepted when s_valid & s_ready
s_din_r / s_din_i  in  data_resolution  input sample
fft_en  out  1  FFT core global enable
fft_rdy  in  1  FFT core CORDIC/twiddle ready
fft_din_r / fft_din_i  out  data_resolution  FFT core input
fft_dout_r / fft_dout_i  in  data_resolution  FFT core output
m_valid  out  1  output sample valid (no backpressure)
m_sop / m_eop  out  1  first/last output of a frame
m_bin  out  cnt_w  frequency bin index of the m_dout sample
m_dout_r / m_dout_i  out  data_resolution  registered FFT output
busy  out  1  state != IDLE
done  out  1  one-cycle pulse when the last output frame completes

Behaviour:
- Reset: state IDLE; all counters 0; all outputs 0 (s_ready, fft_en, m_*, busy, done = 0; fft_din = 0). Reset mid-operation aborts immediately with no flush.
- States:
  - IDLE: cfg_start moves to WAIT_RDY and latches cfg_frames.
  - WAIT_RDY: moves to RUN when fft_rdy = 1.
  - RUN: moves to FLUSH when the last required input frame is accepted. This is frames_in == cfg_frames, or, in continuous mode with stop_pend set, the end of the current input frame.
  - FLUSH: moves to DONE when frames_out reaches the frame target.
  - DONE: one cycle, done = 1, then IDLE.
- stop_pend: set by cfg_stop in RUN; cleared in IDLE. Ignored when cfg_frames != 0. If cfg_stop arrives with in_cnt == 0 and frames_in > 0, RUN moves to FLUSH immediately. If frames_in == 0, the first frame is still taken.
- Input side:
  - s_ready = (RUN) & fft_rdy & frames remaining.
  - fft_en = s_valid & s_ready in RUN; fft_en = fft_rdy in FLUSH; fft_en = 0 otherwise.
  - fft_din = s_din in RUN and 0 in FLUSH. It is combinational from s_din, so the core registers it.
  - A fft_rdy drop or an s_valid gap stalls the core with state held, and no outputs occur during the stall.
- Counters (advance only on fft_en):
  - in_cnt: cnt_w bits, wraps at fft_length; wrap increments frames_in.
  - lat_cnt: saturates at pipe_lat.
  - out_cnt: cnt_w bits, increments only when lat_cnt == pipe_lat; wrap increments frames_out.
- Output frame target: latched cfg_frames, or frames_in at the RUN->FLUSH transition in continuous mode.
- Output capture: on a cycle with fft_en & (lat_cnt == pipe_lat) & (frames_out < target), the next cycle shows:
  - m_valid = 1 and m_dout = fft_dout;
  - m_sop = (out_cnt == 0) and m_eop = (out_cnt == fft_length-1);
  - m_bin = bit-reverse(out_cnt), since the core emits in bit-reversed order.
  Otherwise m_valid, m_sop and m_eop are 0; m_dout and m_bin hold their last values.
- done follows the cycle of the final m_eop by exactly one cycle.
- Simultaneous events: cfg_start while busy is ignored. cfg_stop on the same cycle as a frame wrap ends input at that wrap. Reset has priority over all events.
- Width rules: frames_in and frames_out are 16 bits. In continuous mode they wrap modulo 2^16 and this does not terminate the run.

Test Plan:
1. Hold sys_rst for 3 cycles with random inputs -> every output 0, busy 0; cfg_start during reset has no effect.
2. cfg_frames=1, fft_rdy=1, 256 back-to-back valid samples ->
   - s_ready high for exactly 256 cycles, then 255 FLUSH cycles with fft_din = 0;
   - exactly 256 m_valid pulses: the first with m_sop=1, m_bin=0; the last with m_eop=1, m_bin=255; second pulse m_bin=128;
   - done 1 cycle after the m_eop cycle.
3. fft_rdy held 0 for 20 cycles after start -> fft_en=0 and s_ready=0 throughout; the first acceptance is the cycle fft_rdy rises; output is identical to test 2.
4. cfg_frames=2, s_valid toggling 1/0 -> 512 m_valid pulses with 2 sop/eop pairs; no m_valid on any cycle following a stall; the total count of fft_en cycles = 512+255.
5. cfg_frames=0, cfg_stop at input sample 100 of the third frame -> 156 more samples accepted, then s_ready=0; exactly 768 outputs; done pulses once.
6. Reset asserted mid-RUN at sample 50, then cfg_start -> clean restart; the new frame's first output has m_sop=1, m_bin=0.
